// File: rtl/edge_detection_line_ctrl.sv
// Line-buffer scheduler for a 3x3 Sobel window: tracks VSYNC/DE, rotates three line
// RAMs and emits one registered window strobe per output pixel, plus a flush line.
module edge_detection_line_ctrl #(
   parameter int H_PIXELS = 640,
   parameter int V_LINES  = 480,
   parameter int COL_W    = 10,
   parameter int ROW_W    = 9
) (
   input  logic             I_PCLK,
   input  logic             I_RST,
   input  logic             I_VSYNC,
   input  logic             I_DE,
   output logic             O_WR_EN,
   output logic [COL_W-1:0] O_WR_ADDR,
   output logic [1:0]       O_WR_SEL,
   output logic [COL_W-1:0] O_RD_ADDR,
   output logic [1:0]       O_RD_SEL_TOP,
   output logic [1:0]       O_RD_SEL_MID,
   output logic             O_WIN_VALID,
   output logic [ROW_W-1:0] O_WIN_ROW,
   output logic [COL_W-1:0] O_WIN_COL,
   output logic             O_BORDER,
   output logic             O_FRAME_START,
   output logic             O_FRAME_DONE,
   output logic             O_ERR
);

   typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_WAIT, S_LINE, S_FLUSH} state_t;

   localparam logic [COL_W-1:0] C_H      = COL_W'(H_PIXELS);
   localparam logic [COL_W-1:0] C_H_LAST = COL_W'(H_PIXELS - 1);
   localparam logic [ROW_W-1:0] C_V_LAST = ROW_W'(V_LINES - 1);

   state_t           r_state, w_state_nxt;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [1:0]       r_wsel;

   logic w_in_frame, w_abort, w_pix, w_accept, w_overrun, w_line_end, w_short;
   logic w_flush, w_flush_end, w_frame_start, w_last_row;
   logic [1:0] w_wsel_p1, w_wsel_p2;

   assign w_in_frame    = (r_state == S_WAIT) || (r_state == S_LINE);
   assign w_abort       = w_in_frame && I_VSYNC;
   assign w_pix         = w_in_frame && I_DE && !I_VSYNC;
   assign w_accept      = w_pix && (r_col < C_H);
   assign w_overrun     = w_pix && (r_col >= C_H);
   assign w_line_end    = (r_state == S_LINE) && !I_DE && !I_VSYNC;
   assign w_short       = w_line_end && (r_col < C_H);
   assign w_last_row    = (r_row == C_V_LAST);
   assign w_flush       = (r_state == S_FLUSH);
   assign w_flush_end   = w_flush && (r_col == C_H_LAST);
   assign w_frame_start = w_pix && (r_state == S_WAIT) && (r_row == '0);
   assign w_wsel_p1     = (r_wsel == 2'd2) ? 2'd0 : r_wsel + 2'd1;
   assign w_wsel_p2     = (r_wsel == 2'd0) ? 2'd2 : r_wsel - 2'd1;

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (I_VSYNC) w_state_nxt = S_VSYNC;
         S_VSYNC: if (!I_VSYNC) w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (I_VSYNC)   w_state_nxt = S_VSYNC;
            else if (I_DE) w_state_nxt = S_LINE;
         end
         S_LINE: begin
            if (I_VSYNC)    w_state_nxt = S_VSYNC;
            else if (!I_DE) w_state_nxt = w_last_row ? S_FLUSH : S_WAIT;
         end
         S_FLUSH: if (w_flush_end) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   logic             w_win, w_sel_en, w_border;
   logic [ROW_W-1:0] w_win_row;
   logic [COL_W-1:0] w_win_col;

   // Window outputs for the coming cycle; flush windows sit on the last frame row.
   always_comb begin
      w_win     = (w_accept && (r_row != '0)) || w_flush;
      w_sel_en  = w_accept || w_flush;
      w_win_row = '0;
      w_win_col = '0;
      if (w_flush) begin
         w_win_row = C_V_LAST;
         w_win_col = r_col;
      end else if (w_win) begin
         w_win_row = r_row - ROW_W'(1);
         w_win_col = r_col;
      end
      w_border = w_win && ((w_win_row == '0) || (w_win_row == C_V_LAST) ||
                           (w_win_col == '0) || (w_win_col == C_H_LAST));
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge I_PCLK) begin
      if (I_RST) begin
         r_state       <= S_IDLE;
         r_col         <= '0;
         r_row         <= '0;
         r_wsel        <= 2'd0;
         O_WR_EN       <= 1'b0;
         O_WR_ADDR     <= '0;
         O_WR_SEL      <= 2'd0;
         O_RD_ADDR     <= '0;
         O_RD_SEL_TOP  <= 2'd0;
         O_RD_SEL_MID  <= 2'd0;
         O_WIN_VALID   <= 1'b0;
         O_WIN_ROW     <= '0;
         O_WIN_COL     <= '0;
         O_BORDER      <= 1'b0;
         O_FRAME_START <= 1'b0;
         O_FRAME_DONE  <= 1'b0;
         O_ERR         <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         case (r_state)
            S_VSYNC: if (!I_VSYNC) begin
               r_col  <= '0;
               r_row  <= '0;
               r_wsel <= 2'd0;
            end
            S_WAIT, S_LINE: if (!I_VSYNC) begin
               if (I_DE) begin
                  if (r_col < C_H) r_col <= r_col + COL_W'(1);
               end else if (r_state == S_LINE) begin
                  // Row saturates on the last line; flush windows use a fixed row.
                  r_col  <= '0;
                  r_wsel <= w_wsel_p1;
                  if (!w_last_row) r_row <= r_row + ROW_W'(1);
               end
            end
            S_FLUSH: r_col <= w_flush_end ? '0 : r_col + COL_W'(1);
            default: ;
         endcase

         O_WR_EN       <= w_accept;
         O_WR_ADDR     <= w_accept ? r_col : '0;
         O_WR_SEL      <= w_sel_en ? r_wsel : 2'd0;
         O_RD_SEL_TOP  <= w_sel_en ? w_wsel_p1 : 2'd0;
         O_RD_SEL_MID  <= w_sel_en ? w_wsel_p2 : 2'd0;
         O_WIN_VALID   <= w_win;
         O_WIN_ROW     <= w_win_row;
         O_WIN_COL     <= w_win_col;
         O_RD_ADDR     <= w_win_col;
         O_BORDER      <= w_border;
         O_FRAME_START <= w_frame_start;
         O_FRAME_DONE  <= w_flush_end;

         if (w_frame_start)                          O_ERR <= 1'b0;
         else if (w_abort || w_overrun || w_short)   O_ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_edge_detection_line_ctrl.sv
// Scoreboard bench for edge_detection_line_ctrl on an 8x4 frame: expected strobes are
// queued as stimulus is driven and popped as the DUT produces them.
module tb_edge_detection_line_ctrl;
   localparam int H  = 8;
   localparam int V  = 4;
   localparam int CW = 4;
   localparam int RW = 2;

   logic clk = 1'b0;
   logic rst, vsync, de;
   logic          o_wr_en, o_win_valid, o_border, o_frame_start, o_frame_done, o_err;
   logic [CW-1:0] o_wr_addr, o_rd_addr, o_win_col;
   logic [1:0]    o_wr_sel, o_rd_sel_top, o_rd_sel_mid;
   logic [RW-1:0] o_win_row;

   always #5 clk = ~clk;

   edge_detection_line_ctrl #(.H_PIXELS(H), .V_LINES(V), .COL_W(CW), .ROW_W(RW)) dut (
      .I_PCLK(clk), .I_RST(rst), .I_VSYNC(vsync), .I_DE(de),
      .O_WR_EN(o_wr_en), .O_WR_ADDR(o_wr_addr), .O_WR_SEL(o_wr_sel),
      .O_RD_ADDR(o_rd_addr), .O_RD_SEL_TOP(o_rd_sel_top), .O_RD_SEL_MID(o_rd_sel_mid),
      .O_WIN_VALID(o_win_valid), .O_WIN_ROW(o_win_row), .O_WIN_COL(o_win_col),
      .O_BORDER(o_border), .O_FRAME_START(o_frame_start), .O_FRAME_DONE(o_frame_done),
      .O_ERR(o_err)
   );

   typedef struct {
      logic          wr_en;
      logic [CW-1:0] wr_addr;
      logic [1:0]    wr_sel, top, mid;
      logic          win_valid;
      logic [RW-1:0] win_row;
      logic [CW-1:0] win_col;
      logic          border;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int n_tests = 0, n_fail = 0;
   int c_wr, c_win_line, c_win_flush, c_border, c_fs, c_fd;
   int tb_row, tb_wsel;

   function automatic exp_t make_exp(bit wr, bit valid, int wrow, int col, int wsel);
      exp_t e;
      e.wr_en     = wr;
      e.wr_addr   = wr ? CW'(col) : '0;
      e.wr_sel    = 2'(wsel);
      e.top       = 2'((wsel + 1) % 3);
      e.mid       = 2'((wsel + 2) % 3);
      e.win_valid = valid;
      e.win_row   = valid ? RW'(wrow) : '0;
      e.win_col   = valid ? CW'(col) : '0;
      e.border    = valid && (wrow == 0 || wrow == V-1 || col == 0 || col == H-1);
      return e;
   endfunction

   task automatic push_pixel(int row, int col, int wsel);
      sb_q.push_back(make_exp(1'b1, row > 0, row - 1, col, wsel));
   endtask

   task automatic push_flush(int k, int wsel);
      sb_q.push_back(make_exp(1'b0, 1'b1, V - 1, k, wsel));
   endtask

   // Scoreboard: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (o_frame_start === 1'b1) c_fs++;
      if (o_frame_done === 1'b1)  c_fd++;
      if (o_wr_en === 1'b1 || o_win_valid === 1'b1) begin
         if (o_wr_en === 1'b1) c_wr++;
         if (o_win_valid === 1'b1 && o_wr_en === 1'b1) c_win_line++;
         if (o_win_valid === 1'b1 && o_wr_en !== 1'b1) c_win_flush++;
         if (o_border === 1'b1) c_border++;
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: got wr_en=%b win_valid=%b row=%0d col=%0d, expected no strobe",
                     o_wr_en, o_win_valid, o_win_row, o_win_col);
         end else begin
            mon_e = sb_q.pop_front();
            if (o_wr_en !== mon_e.wr_en || (mon_e.wr_en && o_wr_addr !== mon_e.wr_addr) ||
                o_wr_sel !== mon_e.wr_sel || o_rd_sel_top !== mon_e.top ||
                o_rd_sel_mid !== mon_e.mid || o_win_valid !== mon_e.win_valid ||
                (mon_e.win_valid && (o_win_row !== mon_e.win_row || o_win_col !== mon_e.win_col ||
                                     o_rd_addr !== mon_e.win_col)) ||
                o_border !== mon_e.border) begin
               n_fail++;
               $display("FAIL strobe: got we=%b wa=%0d ws=%0d top=%0d mid=%0d v=%b r=%0d c=%0d ra=%0d b=%b, expected we=%b wa=%0d ws=%0d top=%0d mid=%0d v=%b r=%0d c=%0d b=%b",
                        o_wr_en, o_wr_addr, o_wr_sel, o_rd_sel_top, o_rd_sel_mid, o_win_valid,
                        o_win_row, o_win_col, o_rd_addr, o_border,
                        mon_e.wr_en, mon_e.wr_addr, mon_e.wr_sel, mon_e.top, mon_e.mid,
                        mon_e.win_valid, mon_e.win_row, mon_e.win_col, mon_e.border);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_counts();
      c_wr = 0; c_win_line = 0; c_win_flush = 0; c_border = 0; c_fs = 0; c_fd = 0;
   endtask

   task automatic start_frame();
      de = 1'b0; vsync = 1'b1;
      repeat (2) tick();
      vsync = 1'b0;
      repeat (2) tick();
      tb_row = 0; tb_wsel = 0;
   endtask

   // One line of n_px pixels; the last frame line also queues the flush windows.
   task automatic drive_line(int n_px, bit vs_in_flush);
      bit last;
      for (int i = 0; i < n_px; i++) begin
         de = 1'b1;
         if (i < H) push_pixel(tb_row, i, tb_wsel);
         tick();
      end
      de = 1'b0;
      last = (tb_row == V - 1);
      if (last) for (int k = 0; k < H; k++) push_flush(k, (tb_wsel + 1) % 3);
      tick();
      tb_row++;
      tb_wsel = (tb_wsel + 1) % 3;
      for (int j = 0; j < (last ? H + 3 : 3); j++) begin
         vsync = vs_in_flush && last && (j == 2 || j == 3);
         tick();
      end
      vsync = 1'b0;
   endtask

   task automatic check_drained(string name);
      int budget = 40;
      while (sb_q.size() != 0 && budget > 0) begin
         tick();
         budget--;
      end
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d strobes still outstanding, expected 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; vsync = 1'b0; de = 1'b0;
      for (int i = 0; i < 3; i++) begin
         de = ~de;
         tick();
      end
      n_tests++;
      if ({o_wr_en, o_wr_addr, o_wr_sel, o_rd_addr, o_rd_sel_top, o_rd_sel_mid, o_win_valid,
           o_win_row, o_win_col, o_border, o_frame_start, o_frame_done, o_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got we=%b wv=%b ws=%0d err=%b fs=%b, expected all 0",
                  o_wr_en, o_win_valid, o_wr_sel, o_err, o_frame_start);
      end
      rst = 1'b0;
      clr_counts();
      for (int i = 0; i < 6; i++) begin
         de = ~de;
         tick();
      end
      de = 1'b0;
      n_tests++;
      if (c_wr != 0 || c_win_line + c_win_flush != 0 || c_fs != 0) begin
         n_fail++;
         $display("FAIL reset_no_vsync: got wr=%0d win=%0d fs=%0d, expected 0", c_wr,
                  c_win_line + c_win_flush, c_fs);
      end
   endtask

   task automatic test_clean_frame();
      clr_counts();
      start_frame();
      for (int r = 0; r < V; r++) drive_line(H, 1'b0);
      check_drained("clean");
      n_tests++;
      if (c_wr != 32 || c_win_line != 24 || c_win_flush != 8) begin
         n_fail++;
         $display("FAIL clean_counts: got wr=%0d line_win=%0d flush_win=%0d, expected 32/24/8",
                  c_wr, c_win_line, c_win_flush);
      end
      n_tests++;
      if (c_border != 20) begin
         n_fail++;
         $display("FAIL clean_border: got %0d, expected 20", c_border);
      end
      n_tests++;
      if (c_fs != 1 || c_fd != 1 || o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL clean_pulses: got fs=%0d fd=%0d err=%b, expected 1/1/0", c_fs, c_fd, o_err);
      end
   endtask

   task automatic test_vsync_in_flush();
      clr_counts();
      start_frame();
      for (int r = 0; r < V - 1; r++) drive_line(H, 1'b0);
      drive_line(H, 1'b1);
      check_drained("flush_vsync");
      n_tests++;
      if (c_win_flush != 8 || c_fd != 1 || o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_vsync: got flush_win=%0d fd=%0d err=%b, expected 8/1/0",
                  c_win_flush, c_fd, o_err);
      end
   endtask

   task automatic test_short_line();
      clr_counts();
      start_frame();
      drive_line(H, 1'b0);
      drive_line(6, 1'b0);
      drive_line(H, 1'b0);
      drive_line(H, 1'b0);
      check_drained("short");
      n_tests++;
      if (o_err !== 1'b1 || c_wr != 30 || c_fd != 1) begin
         n_fail++;
         $display("FAIL short_line: got err=%b wr=%0d fd=%0d, expected 1/30/1", o_err, c_wr, c_fd);
      end
   endtask

   task automatic test_long_line();
      int wr_before;
      clr_counts();
      start_frame();
      n_tests++;
      if (o_err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: got %b, expected 1", o_err);
      end
      drive_line(H, 1'b0);
      n_tests++;
      if (o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear_at_start: got %b, expected 0", o_err);
      end
      drive_line(H, 1'b0);
      wr_before = c_wr;
      drive_line(10, 1'b0);
      n_tests++;
      if (c_wr - wr_before != 8 || o_err !== 1'b1) begin
         n_fail++;
         $display("FAIL long_line: got wr=%0d err=%b, expected 8/1", c_wr - wr_before, o_err);
      end
      drive_line(H, 1'b0);
      check_drained("long");
      n_tests++;
      if (c_wr != 32 || c_fd != 1) begin
         n_fail++;
         $display("FAIL long_frame: got wr=%0d fd=%0d, expected 32/1", c_wr, c_fd);
      end
   endtask

   task automatic test_midframe_vsync();
      clr_counts();
      start_frame();
      drive_line(H, 1'b0);
      drive_line(H, 1'b0);
      for (int i = 0; i < 3; i++) begin
         de = 1'b1;
         push_pixel(tb_row, i, tb_wsel);
         tick();
      end
      vsync = 1'b1;
      tick();
      de = 1'b0;
      tick();
      vsync = 1'b0;
      repeat (H + 4) tick();
      check_drained("abort");
      n_tests++;
      if (o_err !== 1'b1 || c_fd != 0 || c_win_flush != 0 || c_wr != 19) begin
         n_fail++;
         $display("FAIL midframe_vsync: got err=%b fd=%0d flush_win=%0d wr=%0d, expected 1/0/0/19",
                  o_err, c_fd, c_win_flush, c_wr);
      end
      clr_counts();
      tb_row = 0; tb_wsel = 0;
      for (int r = 0; r < V; r++) drive_line(H, 1'b0);
      check_drained("after_abort");
      n_tests++;
      if (c_fs != 1 || c_fd != 1 || o_err !== 1'b0 || c_wr != 32) begin
         n_fail++;
         $display("FAIL after_abort: got fs=%0d fd=%0d err=%b wr=%0d, expected 1/1/0/32",
                  c_fs, c_fd, o_err, c_wr);
      end
   endtask

   task automatic test_reset_midframe();
      clr_counts();
      start_frame();
      drive_line(H, 1'b0);
      drive_line(H, 1'b0);
      for (int i = 0; i < 4; i++) begin
         de = 1'b1;
         push_pixel(tb_row, i, tb_wsel);
         tick();
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if ({o_wr_en, o_win_valid, o_wr_sel, o_win_row, o_win_col, o_border, o_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_midframe: got we=%b wv=%b ws=%0d r=%0d c=%0d, expected all 0",
                  o_wr_en, o_win_valid, o_wr_sel, o_win_row, o_win_col);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         de = ~de;
         tick();
      end
      de = 1'b0;
      check_drained("reset_mid");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; vsync = 1'b0; de = 1'b0;
      clr_counts();
      tb_row = 0; tb_wsel = 0;
      test_reset();
      test_clean_frame();
      test_vsync_in_flush();
      test_short_line();
      test_long_line();
      test_clean_frame();
      test_midframe_vsync();
      test_reset_midframe();
      test_clean_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
